// File: rtl/acq_baud_gen.sv
// Acquisition-strobe generator: splits each UART bit into N acquisitions.
// Each bit has U periods of P+1 clocks followed by D periods of P clocks.
module acq_baud_gen #(
  parameter int MIN_PERIOD = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p_Enable_i,
  input  logic        p_Restart_i,
  input  logic [15:0] BaudRateGen_i,
  input  logic [7:0]  BitCompensation_i,
  output logic        p_AcqSig_o,
  output logic        p_MidSig_o,
  output logic        p_BitSig_o,
  output logic [4:0]  AcqIndex_o,
  output logic        p_Busy_o
);

  localparam logic       IDLE  = 1'b0;
  localparam logic       RUN   = 1'b1;
  localparam logic [15:0] MIN_P = 16'(MIN_PERIOD);

  logic        state;
  logic [15:0] ps;
  logic [3:0]  us, ds;
  logic [16:0] cnt;
  logic [4:0]  idx;

  logic [15:0] loadP;
  logic [3:0]  loadU, loadD;
  logic [4:0]  nAcq, lastIdx, midIdx;
  logic [16:0] len;
  logic        acqDone;

  // Candidate shadow values; an empty compensation byte degrades to one P-clock period
  always_comb begin
    loadP = (BaudRateGen_i < MIN_P) ? MIN_P : BaudRateGen_i;
    loadU = BitCompensation_i[7:4];
    loadD = BitCompensation_i[3:0];
    if (loadU == 4'd0 && loadD == 4'd0) loadD = 4'd1;
  end

  always_comb begin
    nAcq    = {1'b0, us} + {1'b0, ds};
    lastIdx = nAcq - 5'd1;
    midIdx  = lastIdx >> 1;
    len     = (idx < {1'b0, us}) ? ({1'b0, ps} + 17'd1) : {1'b0, ps};
    acqDone = (cnt == len - 17'd1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      ps         <= 16'd20;
      us         <= 4'd10;
      ds         <= 4'd5;
      cnt        <= '0;
      idx        <= '0;
      p_AcqSig_o <= 1'b0;
      p_MidSig_o <= 1'b0;
      p_BitSig_o <= 1'b0;
      p_Busy_o   <= 1'b0;
    end else begin
      p_AcqSig_o <= 1'b0;
      p_MidSig_o <= 1'b0;
      p_BitSig_o <= 1'b0;
      if (state == IDLE) begin
        if (p_Enable_i) begin
          state    <= RUN;
          p_Busy_o <= 1'b1;
          cnt      <= '0;
          idx      <= '0;
          ps       <= loadP;
          us       <= loadU;
          ds       <= loadD;
        end
      end else if (!p_Enable_i) begin
        // Disable aborts the bit outright and beats a same-cycle restart
        state    <= IDLE;
        p_Busy_o <= 1'b0;
        cnt      <= '0;
        idx      <= '0;
      end else if (p_Restart_i) begin
        cnt <= '0;
        idx <= '0;
        ps  <= loadP;
        us  <= loadU;
        ds  <= loadD;
      end else if (acqDone) begin
        cnt        <= '0;
        p_AcqSig_o <= 1'b1;
        p_MidSig_o <= (idx == midIdx);
        if (idx == lastIdx) begin
          p_BitSig_o <= 1'b1;
          idx        <= '0;
          ps         <= loadP;
          us         <= loadU;
          ds         <= loadD;
        end else begin
          idx <= idx + 5'd1;
        end
      end else begin
        cnt <= cnt + 17'd1;
      end
    end
  end

  assign AcqIndex_o = idx;

endmodule

// File: tb/tb_acq_baud_gen.sv
// Randomized + directed bench for acq_baud_gen against an arithmetic bit-schedule model.
module tb_acq_baud_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, rs;
  logic [15:0] brg;
  logic [7:0]  comp;
  logic        acq, mid, bitS, busy;
  logic [4:0]  idx;

  acq_baud_gen #(.MIN_PERIOD(2)) dut (
    .clk(clk), .rst(rst), .p_Enable_i(en), .p_Restart_i(rs),
    .BaudRateGen_i(brg), .BitCompensation_i(comp),
    .p_AcqSig_o(acq), .p_MidSig_o(mid), .p_BitSig_o(bitS),
    .AcqIndex_o(idx), .p_Busy_o(busy)
  );

  always #5 clk = ~clk;

  int nCmp = 0, nErr = 0;

  // model: mT = clocks elapsed in the current bit, config latched at bit start
  bit         mRun;
  int         mT, mP, mU, mD;
  logic       eAcq, eMid, eBit, eBusy;
  logic [4:0] eIdx;

  int acqJ[$], midJ[$], bitJ[$];
  logic offBusy;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int doneCnt(input int t);
    if (t < mU * (mP + 1)) return t / (mP + 1);
    return mU + (t - mU * (mP + 1)) / mP;
  endfunction

  task automatic mLoad();
    mP = (brg < 16'd2) ? 2 : int'(brg);
    mU = int'(comp[7:4]);
    mD = int'(comp[3:0]);
    if (mU + mD == 0) mD = 1;
  endtask

  // Expected outputs after the coming posedge, given the inputs now driven
  task automatic mStep();
    int k, n;
    eAcq = 0; eMid = 0; eBit = 0;
    if (!mRun) begin
      if (en) begin mRun = 1; mLoad(); mT = 0; eBusy = 1; end
      eIdx = 0;
    end else if (!en) begin
      mRun = 0; eBusy = 0; eIdx = 0;
    end else if (rs) begin
      mLoad(); mT = 0; eIdx = 0;
    end else begin
      mT++;
      n = mU + mD;
      k = doneCnt(mT);
      if (k != doneCnt(mT - 1)) begin
        eAcq = 1;
        eMid = ((k - 1) == (n - 1) / 2);
        if (k == n) begin
          eBit = 1; mT = 0; mLoad(); eIdx = 0;
        end else eIdx = 5'(k);
      end else eIdx = 5'(k);
    end
  endtask

  task automatic cycle(input bit e, input bit r, input logic [15:0] b, input logic [7:0] c);
    @(negedge clk);
    chk("out{acq,mid,bit,idx,busy}", {23'd0, acq, mid, bitS, idx, busy},
        {23'd0, eAcq, eMid, eBit, eIdx, eBusy});
    en = e; rs = r; brg = b; comp = c;
    mStep();
  endtask

  // Enable, then observe j = 0..n where j counts edges after the enabling edge E
  task automatic run(input int n, input logic [15:0] b, input logic [7:0] c,
                     input int chgAt, input logic [15:0] b2, input logic [7:0] c2,
                     input int rsAt, input int offAt);
    acqJ.delete(); midJ.delete(); bitJ.delete();
    cycle(1, 0, b, c);
    for (int j = 0; j <= n; j++) begin
      cycle((offAt < 0) || (j < offAt), j == rsAt,
            (j >= chgAt) ? b2 : b, (j >= chgAt) ? c2 : c);
      if (acq)  acqJ.push_back(j);
      if (mid)  midJ.push_back(j);
      if (bitS) bitJ.push_back(j);
      if (j == offAt + 1) offBusy = busy;
    end
  endtask

  task automatic goIdle();
    repeat (3) cycle(0, 0, brg, comp);
  endtask

  function automatic int qAt(input int q[$], input int i);
    return (q.size() > i) ? q[i] : -1;
  endfunction

  initial begin
    rst = 1'b0; en = 0; rs = 0; brg = 16'd20; comp = 8'hA5;
    mRun = 0; mT = 0; mP = 20; mU = 10; mD = 5;
    eAcq = 0; eMid = 0; eBit = 0; eBusy = 0; eIdx = 0;
    repeat (3) @(negedge clk);
    chk("resetOut", {27'd0, acq, mid, bitS, idx, busy}, 32'd0);
    rst = 1'b1;
    mStep();
    goIdle();

    // defaults: 10x21 + 5x20 = 310 clocks per bit
    run(620, 20, 8'hA5, 1 << 30, 0, 0, -1, -1);
    chk("defFirstAcq", qAt(acqJ, 0), 21);
    chk("defAcq10", qAt(acqJ, 9), 210);
    chk("defAcq11", qAt(acqJ, 10), 230);
    chk("defMid", qAt(midJ, 0), 168);
    chk("defBit1", qAt(bitJ, 0), 310);
    chk("defBit2", qAt(bitJ, 1), 620);
    goIdle();

    // no round-up periods: P=3, U=0, D=4
    run(30, 3, 8'h04, 1 << 30, 0, 0, -1, -1);
    chk("p3Acq", qAt(acqJ, 0), 3);
    chk("p3Mid", qAt(midJ, 0), 6);
    chk("p3Bit1", qAt(bitJ, 0), 12);
    chk("p3Bit2", qAt(bitJ, 1), 24);
    goIdle();

    // degenerate: clamp to 2, N=1
    run(10, 0, 8'h00, 1 << 30, 0, 0, -1, -1);
    chk("degAcq", qAt(acqJ, 0), 2);
    chk("degMid", qAt(midJ, 0), 2);
    chk("degBit1", qAt(bitJ, 0), 2);
    chk("degBit2", qAt(bitJ, 1), 4);
    goIdle();

    // mid-bit config change takes effect only at the next bit
    run(470, 20, 8'hA5, 99, 10, 8'h0F, -1, -1);
    chk("chgBit1", qAt(bitJ, 0), 310);
    chk("chgBit2", qAt(bitJ, 1), 460);
    goIdle();

    // restart sampled at E+50
    run(100, 20, 8'hA5, 1 << 30, 0, 0, 49, -1);
    chk("rsAcqA", qAt(acqJ, 1), 42);
    chk("rsAcqB", qAt(acqJ, 2), 71);
    goIdle();

    // disable sampled on the edge that would complete the bit
    run(315, 20, 8'hA5, 1 << 30, 0, 0, -1, 309);
    chk("offNoBit", bitJ.size(), 0);
    chk("offBusy", offBusy, 1'b0);
    run(40, 20, 8'hA5, 1 << 30, 0, 0, -1, -1);
    chk("reAcq", qAt(acqJ, 0), 21);
    goIdle();

    // asynchronous reset mid-bit
    run(100, 20, 8'hA5, 1 << 30, 0, 0, -1, -1);
    @(negedge clk);
    #2 rst = 1'b0; en = 0; rs = 0;
    #1 chk("midRstOut", {27'd0, acq, mid, bitS, idx, busy}, 32'd0);
    mRun = 0; eAcq = 0; eMid = 0; eBit = 0; eBusy = 0; eIdx = 0;
    @(negedge clk);
    rst = 1'b1;
    mStep();
    goIdle();
    run(25, 20, 8'hA5, 1 << 30, 0, 0, -1, -1);
    chk("postRstAcq", qAt(acqJ, 0), 21);
    goIdle();

    // randomized run
    begin
      logic e; logic [15:0] b; logic [7:0] c;
      e = 1; b = 16'd5; c = 8'h31;
      for (int i = 0; i < 10000; i++) begin
        if (e) begin if ($urandom_range(0, 299) == 0) e = 0; end
        else if ($urandom_range(0, 9) == 0) e = 1;
        if ($urandom_range(0, 49) == 0) begin
          b = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 40)) : 16'($urandom_range(0, 6));
          c = 8'($urandom);
        end
        cycle(e, $urandom_range(0, 199) == 0, b, c);
      end
    end
    goIdle();

    // maximum period: 0xFFFF+1 must not wrap
    run(65540, 16'hFFFF, 8'h10, 1 << 30, 0, 0, -1, -1);
    chk("maxBit", qAt(bitJ, 0), 65536);
    goIdle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
